// File: rtl/ped_crossing_ctrl.sv
// Pedestrian WALK / DON'T WALK controller slaved to the vehicle light controller.
// Grants WALK at the start of a vehicle red phase and times WALK plus flashing clearance in ticks.
module ped_crossing_ctrl #(
    parameter int WALK_TICKS  = 6,
    parameter int FLASH_TICKS = 4,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic red,
    input  logic yellow,
    input  logic green,
    input  logic ped_button,
    output logic walk,
    output logic dont_walk,
    output logic req_pending,
    output logic served,
    output logic fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        WALK  = 3'd2,
        FLASH = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             red_d_q, red_d_d;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             req_pending_q, req_pending_d;
    logic             served_q, served_d;
    logic             fault_q, fault_d;

    logic red_rise;
    logic lights_legal;
    logic enter_fault;

    assign red_rise     = red & ~red_d_q;
    assign lights_legal = ({red, yellow, green} == 3'b100) ||
                          ({red, yellow, green} == 3'b010) ||
                          ({red, yellow, green} == 3'b001);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        walk_d        = walk_q;
        dont_walk_d   = dont_walk_q;
        req_pending_d = req_pending_q;
        served_d      = 1'b0;
        fault_d       = fault_q;
        red_d_d       = red;

        case (state_q)
            IDLE: begin
                walk_d      = 1'b0;
                dont_walk_d = 1'b1;
                // A red edge coinciding with the press only arms the request.
                if (ped_button) begin
                    state_d       = WAIT;
                    req_pending_d = 1'b1;
                end
            end
            WAIT: begin
                if (red_rise) begin
                    state_d       = WALK;
                    walk_d        = 1'b1;
                    dont_walk_d   = 1'b0;
                    served_d      = 1'b1;
                    cnt_d         = '0;
                    req_pending_d = 1'b0;
                end
            end
            WALK: begin
                if (tick) begin
                    if (cnt_q == WALK_LAST) begin
                        state_d     = FLASH;
                        cnt_d       = '0;
                        walk_d      = 1'b0;
                        dont_walk_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLASH: begin
                if (ped_button) begin
                    req_pending_d = 1'b1;
                end
                if (tick) begin
                    if (cnt_q == FLASH_LAST) begin
                        cnt_d       = '0;
                        dont_walk_d = 1'b1;
                        state_d     = (req_pending_q || ped_button) ? WAIT : IDLE;
                    end else begin
                        cnt_d       = cnt_q + 1'b1;
                        dont_walk_d = ~dont_walk_q;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        // Red leaving while pedestrians may be on the crossing is treated like a bad lamp input.
        enter_fault = !lights_legal || (state_q == FAULT) ||
                      (((state_q == WALK) || (state_q == FLASH)) && !red);
        if (enter_fault) begin
            state_d       = FAULT;
            fault_d       = 1'b1;
            walk_d        = 1'b0;
            dont_walk_d   = 1'b1;
            req_pending_d = 1'b0;
            served_d      = 1'b0;
            cnt_d         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            red_d_q       <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            req_pending_q <= 1'b0;
            served_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            red_d_q       <= red_d_d;
            walk_q        <= walk_d;
            dont_walk_q   <= dont_walk_d;
            req_pending_q <= req_pending_d;
            served_q      <= served_d;
            fault_q       <= fault_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_pending_q;
    assign served      = served_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl; outputs are compared as {walk, dont_walk, req_pending, served, fault}.
module tb_ped_crossing_ctrl;

    logic clk = 1'b0;
    logic reset, tick, red, yellow, green, ped_button;
    logic walk, dont_walk, req_pending, served, fault;

    int n_checks = 0;
    int n_errors = 0;

    ped_crossing_ctrl #(
        .WALK_TICKS (6),
        .FLASH_TICKS(4),
        .CNT_W      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .ped_button (ped_button),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .req_pending(req_pending),
        .served     (served),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit so outputs reflect the last edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    task automatic check_outs(input string tag, input logic [4:0] exp);
        logic [4:0] got;
        got = {walk, dont_walk, req_pending, served, fault};
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (walk,dont_walk,req,served,fault)", tag, got, exp);
        end
    endtask

    task automatic press();
        ped_button = 1'b1;
        cyc(1);
        ped_button = 1'b0;
    endtask

    task automatic set_lights(input logic r, input logic y, input logic g);
        red = r; yellow = y; green = g;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; ped_button = 1'b0;
        set_lights(1, 0, 0);
        cyc(2);
        check_outs("reset_state", 5'b01000);
        reset = 1'b0;

        // Green phase request, served on the next red edge
        set_lights(0, 0, 1);
        cyc(1);
        press();
        check_outs("req_latch", 5'b01100);
        set_lights(1, 0, 0);
        cyc(1);
        check_outs("walk_entry", 5'b10010);
        cyc(1);
        check_outs("served_one_clk", 5'b10000);
        for (int i = 0; i < 5; i++) do_tick();
        check_outs("walk_held_5_ticks", 5'b10000);
        do_tick();
        check_outs("flash_entry", 5'b01000);
        do_tick();
        check_outs("flash_t1", 5'b00000);
        do_tick();
        check_outs("flash_t2", 5'b01000);
        do_tick();
        check_outs("flash_t3", 5'b00000);
        do_tick();
        check_outs("flash_done_idle", 5'b01000);
        cyc(3);
        check_outs("idle_steady", 5'b01000);

        // Request while red already high waits for the next red phase
        press();
        check_outs("req_during_red", 5'b01100);
        cyc(3);
        check_outs("no_walk_same_red", 5'b01100);
        set_lights(0, 1, 0); cyc(1);
        set_lights(0, 0, 1); cyc(1);
        set_lights(0, 1, 0); cyc(1);
        check_outs("still_waiting", 5'b01100);
        set_lights(1, 0, 0); cyc(1);
        check_outs("walk_next_red", 5'b10010);

        // Request during FLASH returns to WAIT
        for (int i = 0; i < 6; i++) do_tick();
        check_outs("flash_entry2", 5'b01000);
        press();
        check_outs("flash_req", 5'b01100);
        do_tick();
        check_outs("flash_req_t1", 5'b00100);
        for (int i = 0; i < 3; i++) do_tick();
        check_outs("flash_to_wait", 5'b01100);
        cyc(2);
        check_outs("wait_no_walk", 5'b01100);
        set_lights(0, 0, 1); cyc(1);
        set_lights(1, 0, 0); cyc(1);
        check_outs("walk_from_wait", 5'b10010);

        // Red dropping during WALK
        cyc(1);
        set_lights(0, 0, 1); cyc(1);
        check_outs("safety_fault", 5'b01001);
        ped_button = 1'b1;
        cyc(3);
        ped_button = 1'b0;
        check_outs("fault_sticky", 5'b01001);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check_outs("fault_cleared", 5'b01000);

        // Reset in the middle of WALK
        press();
        set_lights(1, 0, 0); cyc(1);
        check_outs("walk_before_rst", 5'b10010);
        cyc(1);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check_outs("rst_mid_walk", 5'b01000);

        // Red edge plus button in IDLE only arms; red_d was cleared by reset so this edge is a rise
        press();
        check_outs("rise_plus_btn", 5'b01100);
        cyc(2);
        check_outs("rise_plus_btn_nowalk", 5'b01100);

        // Tick coinciding with red_rise in WAIT is not counted
        set_lights(0, 0, 1); cyc(1);
        set_lights(1, 0, 0); tick = 1'b1; cyc(1); tick = 1'b0;
        check_outs("tick_rise_walk", 5'b10010);
        for (int i = 0; i < 5; i++) do_tick();
        check_outs("tick_rise_not_counted", 5'b10000);
        do_tick();
        check_outs("tick_rise_flash", 5'b01000);
        for (int i = 0; i < 4; i++) do_tick();
        check_outs("back_idle", 5'b01000);

        // Illegal lamp combinations
        set_lights(1, 0, 1); cyc(1);
        set_lights(1, 0, 0);
        check_outs("two_lamps", 5'b01001);
        press();
        check_outs("two_lamps_sticky", 5'b01001);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check_outs("reset_after_two", 5'b01000);
        set_lights(0, 0, 0); cyc(1);
        set_lights(1, 0, 0);
        check_outs("no_lamps", 5'b01001);
        reset = 1'b1; cyc(1); reset = 1'b0;
        check_outs("final_reset", 5'b01000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Downstream consumer of the vehicle light controller. Takes its red/yellow/green outputs and the shared tick pulse and drives the pedestrian WALK / DON'T WALK heads for the same junction.
- Latches pedestrian button requests and grants WALK only at the start of a vehicle red phase.
- Times WALK and a flashing DON'T WALK clearance interval in ticks.
- Forces a safe state on any inconsistent vehicle-light input.

Parameters:
- WALK_TICKS, 6: ticks WALK is held steady; legal range 1..2^CNT_W-1.
- FLASH_TICKS, 4: ticks of flashing DON'T WALK clearance; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the internal tick counter.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-clk-wide timebase pulse shared with the vehicle light controller.
- red, input, 1: vehicle red lamp.
- yellow, input, 1: vehicle yellow lamp.
- green, input, 1: vehicle green lamp.
- ped_button, input, 1: pedestrian request, level, already synchronised and debounced.
- walk, output, 1: steady WALK lamp.
- dont_walk, output, 1: DON'T WALK lamp; flashes during clearance.
- req_pending, output, 1: request latched, not yet served.
- served, output, 1: one-clk pulse on WALK entry.
- fault, output, 1: sticky illegal-input flag.

Behaviour:
- Interface fixed: one clock `clk`; `reset` is synchronous and active-high.
- All outputs are registered.
- Reset values: walk=0, dont_walk=1, req_pending=0, served=0, fault=0, state=IDLE, counter=0, red_d=0.
- Reset mid-operation: everything returns to the reset values on the next edge; a held ped_button re-latches on the following cycle.
- red_d is red delayed by one clk. red_rise = red & ~red_d.
- Legal lights: exactly one of red/yellow/green high.
- Illegal lights (0 or ≥2 lamps high) in any state set fault=1 the next cycle. Also, while fault=1: state=FAULT, walk=0, dont_walk=1 steady, req_pending=0.
- FAULT is left only by reset.
- States and transitions:
  - IDLE: walk=0, dont_walk=1. ped_button=1 → WAIT, req_pending=1 the next cycle.
  - WAIT: wait for red_rise; a request made while red is already high waits for the next red phase.
    - red_rise → WALK next cycle: walk=1, dont_walk=0, served=1 for that one cycle, counter=0, req_pending=0.
  - WALK: counter increments on each tick.
    - tick with counter==WALK_TICKS-1 → FLASH next cycle, counter=0, dont_walk=1, walk=0.
    - ped_button in WALK is ignored.
  - FLASH: on each tick, dont_walk toggles and the counter increments. The first FLASH cycle shows dont_walk=1.
    - tick with counter==FLASH_TICKS-1 → next cycle dont_walk=1 steady, counter=0.
    - Next state is WAIT if req_pending=1, else IDLE.
    - ped_button in FLASH sets req_pending=1.
- Safety rule: red deasserting while in WALK or FLASH (even to a legal lamp) sets fault=1 and enters FAULT the next cycle.
- Simultaneous events in the same cycle:
  - Illegal input wins over everything.
  - red_rise together with ped_button in IDLE goes only to WAIT; no WALK until the next red_rise.
- tick and red_rise in the same cycle in WAIT: enter WALK; that tick does not count.
- Counter arithmetic is CNT_W-bit unsigned and never wraps because the terminal compare precedes overflow.
- Latency: ped_button→req_pending is 1 clk; red_rise→walk is 1 clk; last timing tick→state change is 1 clk.

Test Plan:
1. Reset asserted 2 clk with red=1 → walk=0, dont_walk=1, req_pending=0, fault=0. Hold reset mid-WALK for 1 clk → outputs return to reset values next edge.
2. Green phase, press ped_button 1 clk → req_pending=1. Switch to red → walk=1 and served=1 one clk after the red edge. After 6 ticks → walk=0, dont_walk=1. Over the next 4 ticks dont_walk goes 1,0,1,0, then steady 1, state IDLE.
3. Press ped_button while red already high → no WALK that phase. Cycle yellow→green→yellow→red → WALK starts one clk after the new red_rise.
4. Press ped_button during FLASH → req_pending=1. After FLASH ends → state WAIT, dont_walk=1. WALK begins on the next red_rise.
5. During WALK drive red=0, green=1 → fault=1, walk=0, dont_walk=1 next clk. Fault stays high through further button presses until reset.
6. In IDLE drive red=1, green=1 simultaneously for 1 clk → fault=1. Separately, drive all lamps 0 → fault=1. Pulse reset → fault=0.
